// File: rtl/text_writer.sv
// Byte-stream terminal front end: turns characters into VRAM cell writes and scroll control.
// Optional feature: define TEXT_WRITER_TAB_EN to make 0x09 advance to the next 8-column tab stop.
module text_writer #(
  parameter int          COLS  = 100,
  parameter int          ROWS  = 30,
  parameter logic [7:0]  BLANK = 8'h20
) (
  input  logic       clk,
  input  logic       reset_low,
  input  logic       in_valid,
  input  logic [7:0] in_char,
  output logic       in_ready,
  output logic [4:0] top_row,
  output logic       vram_we,
  output logic [4:0] vram_wr_row,
  output logic [6:0] vram_wr_col,
  output logic [7:0] vram_wr_char,
  output logic [4:0] cursor_row,
  output logic [6:0] cursor_col
);

  localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);
  localparam logic [6:0] LAST_COL = 7'(COLS - 1);

  typedef enum logic [1:0] {CLEAR, IDLE, SCROLL} state_t;

  state_t     state, state_next;
  logic [4:0] sweep_row, sweep_row_next;
  logic [6:0] sweep_col, sweep_col_next;
  logic       sweep_done, sweep_done_next;
  logic [4:0] scroll_row, scroll_row_next;
  logic [4:0] top_row_next, cursor_row_next, wr_row_next;
  logic [6:0] cursor_col_next, wr_col_next;
  logic [7:0] wr_char_next;
  logic       we_next, line_feed;

  logic       accept, is_print, at_last_col, at_last_row, scroll_start;
  logic [5:0] phys_sum;
  logic [4:0] phys_row;

  assign accept       = in_valid && in_ready;
  assign is_print     = (in_char >= 8'h20) && (in_char <= 8'h7E);
  assign at_last_col  = (cursor_col == LAST_COL);
  assign at_last_row  = (cursor_row == LAST_ROW);
  assign scroll_start = accept && at_last_row &&
                        ((in_char == 8'h0A) || (is_print && at_last_col));
  assign phys_sum     = {1'b0, cursor_row} + {1'b0, top_row};
  assign phys_row     = (phys_sum >= 6'(ROWS)) ? 5'(phys_sum - 6'(ROWS)) : phys_sum[4:0];

`ifdef TEXT_WRITER_TAB_EN
  logic [7:0] tab_stop;
  assign tab_stop = {1'b0, cursor_col | 7'd7} + 8'd1;
`endif

  always_ff @(posedge clk or negedge reset_low) begin
    if (!reset_low) state <= CLEAR;
    else            state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      CLEAR:   if (sweep_done) state_next = IDLE;
      IDLE:    if (scroll_start) state_next = SCROLL;
      SCROLL:  if (sweep_done) state_next = IDLE;
      default: state_next = CLEAR;
    endcase
  end

  assign in_ready = (state == IDLE);

  // Next values for every registered output; sweep_done adds one idle slot after the last write.
  always_comb begin
    sweep_row_next  = sweep_row;
    sweep_col_next  = sweep_col;
    sweep_done_next = sweep_done;
    scroll_row_next = scroll_row;
    top_row_next    = top_row;
    cursor_row_next = cursor_row;
    cursor_col_next = cursor_col;
    wr_row_next     = vram_wr_row;
    wr_col_next     = vram_wr_col;
    wr_char_next    = vram_wr_char;
    we_next         = 1'b0;
    line_feed       = 1'b0;
    case (state)
      CLEAR: begin
        if (!sweep_done) begin
          we_next      = 1'b1;
          wr_row_next  = sweep_row;
          wr_col_next  = sweep_col;
          wr_char_next = BLANK;
          if (sweep_col == LAST_COL) begin
            sweep_col_next = '0;
            if (sweep_row == LAST_ROW) sweep_done_next = 1'b1;
            else                       sweep_row_next  = sweep_row + 5'd1;
          end else begin
            sweep_col_next = sweep_col + 7'd1;
          end
        end else begin
          sweep_done_next = 1'b0;
          sweep_row_next  = '0;
        end
      end
      SCROLL: begin
        if (!sweep_done) begin
          we_next      = 1'b1;
          wr_row_next  = scroll_row;
          wr_col_next  = sweep_col;
          wr_char_next = BLANK;
          if (sweep_col == LAST_COL) begin
            sweep_col_next  = '0;
            sweep_done_next = 1'b1;
          end else begin
            sweep_col_next = sweep_col + 7'd1;
          end
        end else begin
          sweep_done_next = 1'b0;
        end
      end
      IDLE: begin
        if (accept) begin
          if (is_print) begin
            we_next      = 1'b1;
            wr_row_next  = phys_row;
            wr_col_next  = cursor_col;
            wr_char_next = in_char;
            if (at_last_col) begin
              cursor_col_next = '0;
              line_feed       = 1'b1;
            end else begin
              cursor_col_next = cursor_col + 7'd1;
            end
          end else begin
            case (in_char)
              8'h0D: cursor_col_next = '0;
              8'h0A: line_feed = 1'b1;
              8'h08: if (cursor_col != 7'd0) cursor_col_next = cursor_col - 7'd1;
`ifdef TEXT_WRITER_TAB_EN
              8'h09: cursor_col_next = (tab_stop > {1'b0, LAST_COL}) ? LAST_COL : tab_stop[6:0];
`endif
              default: ;
            endcase
          end
          if (line_feed) begin
            if (!at_last_row) begin
              cursor_row_next = cursor_row + 5'd1;
            end else begin
              scroll_row_next = top_row;
              top_row_next    = (top_row == LAST_ROW) ? 5'd0 : top_row + 5'd1;
            end
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_low) begin
    if (!reset_low) begin
      sweep_row    <= '0;
      sweep_col    <= '0;
      sweep_done   <= 1'b0;
      scroll_row   <= '0;
      top_row      <= '0;
      cursor_row   <= '0;
      cursor_col   <= '0;
      vram_we      <= 1'b0;
      vram_wr_row  <= '0;
      vram_wr_col  <= '0;
      vram_wr_char <= BLANK;
    end else begin
      sweep_row    <= sweep_row_next;
      sweep_col    <= sweep_col_next;
      sweep_done   <= sweep_done_next;
      scroll_row   <= scroll_row_next;
      top_row      <= top_row_next;
      cursor_row   <= cursor_row_next;
      cursor_col   <= cursor_col_next;
      vram_we      <= we_next;
      vram_wr_row  <= wr_row_next;
      vram_wr_col  <= wr_col_next;
      vram_wr_char <= wr_char_next;
    end
  end

endmodule

// File: tb/tb_text_writer.sv
// Directed bench for text_writer: clear sweep, byte decode table, wrap, scroll and reset abort.
module tb_text_writer;

  logic       clk = 1'b0;
  logic       reset_low = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_char = 8'h00;
  logic       in_ready, vram_we;
  logic [4:0] top_row, vram_wr_row, cursor_row;
  logic [6:0] vram_wr_col, cursor_col;
  logic [7:0] vram_wr_char;

  int checks = 0;
  int errors = 0;

  text_writer dut (
    .clk(clk), .reset_low(reset_low), .in_valid(in_valid), .in_char(in_char),
    .in_ready(in_ready), .top_row(top_row), .vram_we(vram_we),
    .vram_wr_row(vram_wr_row), .vram_wr_col(vram_wr_col), .vram_wr_char(vram_wr_char),
    .cursor_row(cursor_row), .cursor_col(cursor_col)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] ch;
    logic       we;
    logic [4:0] row;
    logic [6:0] col;
    logic [4:0] cur_row;
    logic [6:0] cur_col;
  } vec_t;

  vec_t vecs[14];

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_ready(input int budget);
    int n = 0;
    while (!in_ready && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check_output("ready_timeout", 32'(in_ready), 32'd1);
  endtask

  // Leaves the caller at the negedge just after the accepting edge.
  task automatic apply_stimulus(input logic [7:0] ch);
    wait_ready(200);
    in_valid = 1'b1;
    in_char  = ch;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic reset_and_clear();
    in_valid  = 1'b0;
    reset_low = 1'b0;
    repeat (3) @(negedge clk);
    reset_low = 1'b1;
    @(negedge clk);
    wait_ready(3100);
  endtask

  task automatic check_scroll(input logic [4:0] old_top, input string tag);
    int bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!vram_we || in_ready || vram_wr_row !== old_top ||
          vram_wr_col !== 7'(i) || vram_wr_char !== 8'h20) bad++;
    end
    @(negedge clk);
    check_output({tag, "_cells"}, 32'(bad), 32'd0);
    check_output({tag, "_ready_we"}, {30'd0, in_ready, vram_we}, 32'h2);
  endtask

  initial begin
    int n_we, bad, first_cyc, last_cyc, ready_cyc;
    logic [4:0] er, old_top;
    logic [6:0] ec;

    vecs[0]  = '{8'h41, 1'b1, 5'd0, 7'd0, 5'd0, 7'd1};
    vecs[1]  = '{8'h42, 1'b1, 5'd0, 7'd1, 5'd0, 7'd2};
    vecs[2]  = '{8'h08, 1'b0, 5'd0, 7'd0, 5'd0, 7'd1};
    vecs[3]  = '{8'h0D, 1'b0, 5'd0, 7'd0, 5'd0, 7'd0};
    vecs[4]  = '{8'h08, 1'b0, 5'd0, 7'd0, 5'd0, 7'd0};
    vecs[5]  = '{8'h07, 1'b0, 5'd0, 7'd0, 5'd0, 7'd0};
    vecs[6]  = '{8'h0A, 1'b0, 5'd0, 7'd0, 5'd1, 7'd0};
    vecs[7]  = '{8'h63, 1'b1, 5'd1, 7'd0, 5'd1, 7'd1};
    vecs[8]  = '{8'h7E, 1'b1, 5'd1, 7'd1, 5'd1, 7'd2};
    vecs[9]  = '{8'h7F, 1'b0, 5'd0, 7'd0, 5'd1, 7'd2};
    vecs[10] = '{8'h21, 1'b1, 5'd1, 7'd2, 5'd1, 7'd3};
`ifdef TEXT_WRITER_TAB_EN
    vecs[11] = '{8'h09, 1'b0, 5'd0, 7'd0, 5'd1, 7'd8};
    vecs[12] = '{8'h1F, 1'b0, 5'd0, 7'd0, 5'd1, 7'd8};
`else
    vecs[11] = '{8'h09, 1'b0, 5'd0, 7'd0, 5'd1, 7'd3};
    vecs[12] = '{8'h1F, 1'b0, 5'd0, 7'd0, 5'd1, 7'd3};
`endif
    vecs[13] = '{8'h0D, 1'b0, 5'd0, 7'd0, 5'd1, 7'd0};

    repeat (3) @(negedge clk);
    check_output("rst_ready", 32'(in_ready), 32'd0);
    check_output("rst_we", 32'(vram_we), 32'd0);
    check_output("rst_top", 32'(top_row), 32'd0);
    check_output("rst_wr_pos", {20'd0, vram_wr_row, vram_wr_col}, 32'd0);
    check_output("rst_wr_char", 32'(vram_wr_char), 32'h20);
    check_output("rst_cursor", {20'd0, cursor_row, cursor_col}, 32'd0);

    // Power-up clear: every cell, row-major, one per cycle.
    reset_low = 1'b1;
    n_we = 0; bad = 0; first_cyc = -1; last_cyc = -1; ready_cyc = -1;
    er = '0; ec = '0;
    for (int c = 1; c <= 3100 && ready_cyc < 0; c++) begin
      @(negedge clk);
      if (in_ready) ready_cyc = c;
      if (vram_we) begin
        if (first_cyc < 0) first_cyc = c;
        if (in_ready || vram_wr_row !== er || vram_wr_col !== ec || vram_wr_char !== 8'h20) bad++;
        n_we++;
        last_cyc = c;
        if (ec == 7'd99) begin ec = '0; er++; end
        else ec++;
      end
    end
    check_output("clear_first_cycle", 32'(first_cyc), 32'd1);
    check_output("clear_count", 32'(n_we), 32'd3000);
    check_output("clear_span", 32'(last_cyc - first_cyc + 1), 32'd3000);
    check_output("clear_cells", 32'(bad), 32'd0);
    check_output("clear_ready_cycle", 32'(ready_cyc), 32'(last_cyc + 1));
    check_output("clear_top", 32'(top_row), 32'd0);

    for (int i = 0; i < 14; i++) begin
      apply_stimulus(vecs[i].ch);
      check_output($sformatf("vec%0d_we", i), 32'(vram_we), 32'(vecs[i].we));
      if (vecs[i].we)
        check_output($sformatf("vec%0d_write", i),
                     {12'd0, vram_wr_row, vram_wr_col, vram_wr_char},
                     {12'd0, vecs[i].row, vecs[i].col, vecs[i].ch});
      check_output($sformatf("vec%0d_cursor", i), {20'd0, cursor_row, cursor_col},
                   {20'd0, vecs[i].cur_row, vecs[i].cur_col});
    end

    // Back-to-back: valid held high across two bytes.
    wait_ready(10);
    in_valid = 1'b1; in_char = 8'h58;
    @(negedge clk);
    in_char = 8'h59;
    check_output("b2b_first", {11'd0, vram_we, vram_wr_row, vram_wr_col, vram_wr_char},
                 {11'd0, 1'b1, 5'd1, 7'd0, 8'h58});
    @(negedge clk);
    in_valid = 1'b0;
    check_output("b2b_second", {11'd0, vram_we, vram_wr_row, vram_wr_col, vram_wr_char},
                 {11'd0, 1'b1, 5'd1, 7'd1, 8'h59});

    // 100 printables from (0,0) wrap to (1,0) without scrolling.
    reset_and_clear();
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      apply_stimulus(8'h61 + 8'(i % 26));
      if (!vram_we || vram_wr_row !== 5'd0 || vram_wr_col !== 7'(i) ||
          vram_wr_char !== 8'h61 + 8'(i % 26)) bad++;
    end
    check_output("wrap_writes", 32'(bad), 32'd0);
    check_output("wrap_cursor", {20'd0, cursor_row, cursor_col}, {20'd0, 5'd1, 7'd0});
    n_we = 0;
    repeat (5) begin
      @(negedge clk);
      if (vram_we) n_we++;
    end
    check_output("wrap_no_scroll", 32'(n_we), 32'd0);
    check_output("wrap_top", 32'(top_row), 32'd0);

    for (int i = 0; i < 57; i++) apply_stimulus(8'h2E);
    check_output("cr_before", 32'(cursor_col), 32'd57);
    apply_stimulus(8'h0D);
    check_output("cr_col57", {24'd0, vram_we, cursor_col}, 32'd0);

    repeat (28) apply_stimulus(8'h0A);
    repeat (5) apply_stimulus(8'h78);
    check_output("pre_scroll_cursor", {20'd0, cursor_row, cursor_col}, {20'd0, 5'd29, 7'd5});
    apply_stimulus(8'h0A);
    check_output("lf_scroll_top", 32'(top_row), 32'd1);
    check_output("lf_scroll_slot", {30'd0, in_ready, vram_we}, 32'd0);
    check_scroll(5'd0, "scroll0");
    check_output("scroll0_cursor", {20'd0, cursor_row, cursor_col}, {20'd0, 5'd29, 7'd5});
    apply_stimulus(8'h43);
    check_output("after_scroll_write", {11'd0, vram_we, vram_wr_row, vram_wr_col, vram_wr_char},
                 {11'd0, 1'b1, 5'd0, 7'd5, 8'h43});

    // 29 more bottom-line feeds walk top_row 1..29 and back to 0.
    old_top = 5'd1;
    for (int k = 0; k < 29; k++) begin
      apply_stimulus(8'h0A);
      check_output($sformatf("lf%0d_top", k), 32'(top_row),
                   32'((old_top == 5'd29) ? 5'd0 : old_top + 5'd1));
      check_scroll(old_top, $sformatf("lf%0d", k));
      old_top = (old_top == 5'd29) ? 5'd0 : old_top + 5'd1;
    end
    check_output("top_wrapped", 32'(top_row), 32'd0);

    // Printable at (29,99) writes with the old top_row, then scrolls.
    apply_stimulus(8'h0D);
    repeat (99) apply_stimulus(8'h7A);
    check_output("pre_wrap_scroll_col", 32'(cursor_col), 32'd99);
    apply_stimulus(8'h51);
    check_output("wrap_scroll_write", {11'd0, vram_we, vram_wr_row, vram_wr_col, vram_wr_char},
                 {11'd0, 1'b1, 5'd29, 7'd99, 8'h51});
    check_output("wrap_scroll_top", 32'(top_row), 32'd1);
    check_output("wrap_scroll_cursor", {20'd0, cursor_row, cursor_col}, {20'd0, 5'd29, 7'd0});
    check_scroll(5'd0, "wrapscroll");

`ifdef TEXT_WRITER_TAB_EN
    repeat (97) apply_stimulus(8'h2D);
    apply_stimulus(8'h09);
    check_output("tab_cap", {24'd0, vram_we, cursor_col}, 32'd99);
`endif

    // Reset in the middle of a scroll restarts the clear sweep.
    apply_stimulus(8'h0A);
    repeat (10) @(negedge clk);
    reset_low = 1'b0;
    #1;
    check_output("abort_outputs", {25'd0, in_ready, vram_we, top_row}, 32'd0);
    @(negedge clk);
    reset_low = 1'b1;
    @(negedge clk);
    check_output("abort_restart", {11'd0, vram_we, vram_wr_row, vram_wr_col, vram_wr_char},
                 {11'd0, 1'b1, 5'd0, 7'd0, 8'h20});
    wait_ready(3100);
    check_output("abort_cursor", {15'd0, top_row, cursor_row, cursor_col}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/text_writer.md
Name: text_writer

Overview:
- Upstream terminal stage that turns a byte stream into VRAM writes and scroll control for the 100x30 text display pipeline.
- Accepts characters over a valid/ready handshake and keeps a cursor.
- Handles CR, LF, BS, wrap and scroll. Drives `top_row`, which the display stage uses as the physical VRAM row shown at the top of the screen.
- Clears the whole VRAM after reset, and clears the newly exposed line on every scroll.

Parameters:
- COLS, 100, characters per row; must be ≤ 128.
- ROWS, 30, text rows; must be ≤ 32.
- BLANK, 8'h20, character written when clearing.

Ports:
- clk  in  1  pixel clock; the only clock.
- reset_low  in  1  asynchronous, active-low reset.
- in_valid  in  1  in_char is valid.
- in_char  in  8  character or control byte.
- in_ready  out  1  block can accept a byte this cycle.
- top_row  out  5  physical VRAM row displayed as screen row 0.
- vram_we  out  1  VRAM write strobe, one cycle per cell.
- vram_wr_row  out  5  physical VRAM row to write.
- vram_wr_col  out  7  VRAM column to write.
- vram_wr_char  out  8  byte to write.
- cursor_row  out  5  logical cursor row, 0..ROWS-1.
- cursor_col  out  7  cursor column, 0..COLS-1.

Behaviour:
- Reset (async assert, sync release):
  - state = CLEAR, clear counters = 0, top_row = 0, cursor = (0,0).
  - vram_we = 0, vram_wr_row/col = 0, vram_wr_char = BLANK, in_ready = 0.
  - Asserting reset mid-operation aborts everything and restarts CLEAR after release.
- Handshake:
  - A byte is accepted on a clk edge with in_valid && in_ready.
  - in_ready = 1 only in IDLE.
  - in_char must be held while in_valid && !in_ready.
- All VRAM outputs are registered. The write for an accepted byte appears on the cycle after acceptance, so back-to-back bytes sustain one write per cycle.
- Physical row = cursor_row + top_row, minus ROWS if the sum is ≥ ROWS. Compute with a 6-bit sum.
- CLEAR state:
  - One write per cycle of BLANK to every cell, row-major: (0,0), (0,1) … (ROWS-1, COLS-1). That is ROWS*COLS writes, 3000 at default.
  - Enter IDLE after the last write; in_ready rises the cycle after the last vram_we.
- IDLE state, byte decode:
  - 0x20..0x7E printable: write at (physical row, cursor_col), then cursor_col + 1.
    - If cursor_col was COLS-1: cursor_col = 0 and perform a line feed (below).
  - 0x0D CR: cursor_col = 0; no write.
  - 0x0A LF: if cursor_row < ROWS-1 then cursor_row + 1; no write. Otherwise scroll (below).
  - 0x08 BS: if cursor_col > 0 then cursor_col − 1; no write, no erase. At column 0, no change.
  - Any other byte: consumed, no effect.
- Scroll (LF or wrap at cursor_row = ROWS-1):
  - Old top physical row R is latched as the line to clear.
  - top_row = R+1, wrapping ROWS-1 → 0, updated on the accept edge.
  - cursor_row stays ROWS-1; state → SCROLL.
  - A printable that wraps into a scroll still performs its own write first, on the cycle after accept. Its physical row is computed with the old top_row.
- SCROLL state:
  - COLS consecutive writes of BLANK to physical row R, cols 0..COLS-1, starting the cycle after the scroll-triggering write slot.
  - in_ready = 0 throughout; return to IDLE after the last write.
- vram_we is never asserted outside the cases above.

Optional Feature:
- Macro: TEXT_WRITER_TAB_EN.
- Defined: 0x09 sets cursor_col to the next multiple of 8, capped at COLS-1. No write, no wrap, no scroll.
- Undefined: 0x09 falls in the "other byte" class and is consumed with no effect.

Test Plan:
- Release reset: exactly 3000 vram_we pulses with char 0x20, first at (0,0), last at (29,99), one per cycle. in_ready = 1 on the following cycle; top_row = 0.
- Send 0x41 after clear: next cycle vram_we = 1 at row 0, col 0, char 0x41; cursor = (0,1). Then send 0x42 back-to-back: write at (0,1) on the next cycle.
- Send 100 printable bytes from (0,0): the 100th writes col 99; cursor becomes (1,0); no scroll writes.
- Cursor at (29,5), send LF:
  - top_row 0 → 1.
  - 100 writes of 0x20 to physical row 0, cols 0..99; in_ready low for those 100 cycles.
  - Then 0x43 writes physical row 0, col 5.
- Repeat LF at the bottom 30 times: top_row goes 1..29 then wraps to 0; each scroll clears the previous top row.
- BS at col 0 → col stays 0. CR at col 57 → col 0. Byte 0x07 → no write, no cursor change.
- With TAB_EN: TAB at col 3 → 8; TAB at col 97 → 99. Without it: TAB at col 3 → col stays 3.
